systolic_tile: RTL and testbench

// - 8x8 output-stationary systolic array tile for matrix multiply C = A x B (16-bit operands, 16-bit accumulators).
// - Row operands enter the west edge and move east one PE per cycle; column operands enter the north edge and move south.
// - Each PE multiply-accumulates its local pair and exposes its accumulator as a result output.
// - East/south edge outputs allow tiles to be chained into larger arrays.

---
 rtl/systolic_pkg.sv | 6 +
 rtl/systolic_pe.sv | 28 ++
 rtl/systolic_tile.sv | 59 +++++
 tb/tb_systolic_tile.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared width, tile size and data type for the systolic tile
package systolic_pkg;
  localparam int DATA_W = 16;
  localparam int TILE_SIZE = 8;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: one MAC cell; forwards a east and b south, accumulates a_in*b_in mod 2^DATA_W
module systolic_pe
  import systolic_pkg::*;
(
  input  logic  CLK,
  input  logic  RST_N,
  input  logic  EN,
  input  data_t a_in,
  input  data_t b_in,
  output data_t a_out,
  output data_t b_out,
  output data_t acc
);
  data_t r_a, r_b, r_acc;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_a <= '0;
      r_b <= '0;
      r_acc <= '0;
    end else if (EN) begin
      r_a <= a_in;
      r_b <= b_in;
      r_acc <= r_acc + a_in * b_in;
    end
  assign a_out = r_a;
  assign b_out = r_b;
  assign acc = r_acc;
endmodule

// File: rtl/systolic_tile.sv
// systolic_tile: 8x8 output-stationary systolic MAC array; rows enter west, columns enter north
module systolic_tile
  import systolic_pkg::*;
(
  input  logic  CLK,
  input  logic  RST_N,
  input  logic  EN,
  input  data_t N_R0X, N_R1X, N_R2X, N_R3X, N_R4X, N_R5X, N_R6X, N_R7X,
  input  data_t N_C0X, N_C1X, N_C2X, N_C3X, N_C4X, N_C5X, N_C6X, N_C7X,
  output data_t Y_00, Y_01, Y_02, Y_03, Y_04, Y_05, Y_06, Y_07,
  output data_t Y_10, Y_11, Y_12, Y_13, Y_14, Y_15, Y_16, Y_17,
  output data_t Y_20, Y_21, Y_22, Y_23, Y_24, Y_25, Y_26, Y_27,
  output data_t Y_30, Y_31, Y_32, Y_33, Y_34, Y_35, Y_36, Y_37,
  output data_t Y_40, Y_41, Y_42, Y_43, Y_44, Y_45, Y_46, Y_47,
  output data_t Y_50, Y_51, Y_52, Y_53, Y_54, Y_55, Y_56, Y_57,
  output data_t Y_60, Y_61, Y_62, Y_63, Y_64, Y_65, Y_66, Y_67,
  output data_t Y_70, Y_71, Y_72, Y_73, Y_74, Y_75, Y_76, Y_77,
  output data_t N_R0Y, N_R1Y, N_R2Y, N_R3Y, N_R4Y, N_R5Y, N_R6Y, N_R7Y,
  output data_t N_C0Y, N_C1Y, N_C2Y, N_C3Y, N_C4Y, N_C5Y, N_C6Y, N_C7Y
);
  // w_a[i][j] is the a operand entering PE(i,j); column TILE_SIZE is the east edge.
  // w_b[i][j] is the b operand entering PE(i,j); row TILE_SIZE is the south edge.
  wire data_t w_a [TILE_SIZE][TILE_SIZE+1];
  wire data_t w_b [TILE_SIZE+1][TILE_SIZE];
  wire data_t [TILE_SIZE-1:0] w_rx, w_cx, w_ry, w_cy;
  wire data_t [TILE_SIZE*TILE_SIZE-1:0] w_y;
  assign w_rx = {N_R7X, N_R6X, N_R5X, N_R4X, N_R3X, N_R2X, N_R1X, N_R0X};
  assign w_cx = {N_C7X, N_C6X, N_C5X, N_C4X, N_C3X, N_C2X, N_C1X, N_C0X};
  assign {N_R7Y, N_R6Y, N_R5Y, N_R4Y, N_R3Y, N_R2Y, N_R1Y, N_R0Y} = w_ry;
  assign {N_C7Y, N_C6Y, N_C5Y, N_C4Y, N_C3Y, N_C2Y, N_C1Y, N_C0Y} = w_cy;
  assign {Y_77, Y_76, Y_75, Y_74, Y_73, Y_72, Y_71, Y_70,
          Y_67, Y_66, Y_65, Y_64, Y_63, Y_62, Y_61, Y_60,
          Y_57, Y_56, Y_55, Y_54, Y_53, Y_52, Y_51, Y_50,
          Y_47, Y_46, Y_45, Y_44, Y_43, Y_42, Y_41, Y_40,
          Y_37, Y_36, Y_35, Y_34, Y_33, Y_32, Y_31, Y_30,
          Y_27, Y_26, Y_25, Y_24, Y_23, Y_22, Y_21, Y_20,
          Y_17, Y_16, Y_15, Y_14, Y_13, Y_12, Y_11, Y_10,
          Y_07, Y_06, Y_05, Y_04, Y_03, Y_02, Y_01, Y_00} = w_y;
  for (genvar i = 0; i < TILE_SIZE; i++) begin : g_edge
    assign w_a[i][0] = w_rx[i];
    assign w_b[0][i] = w_cx[i];
    assign w_ry[i] = w_a[i][TILE_SIZE];
    assign w_cy[i] = w_b[TILE_SIZE][i];
  end
  for (genvar r = 0; r < TILE_SIZE; r++) begin : g_row
    for (genvar c = 0; c < TILE_SIZE; c++) begin : g_col
      systolic_pe u_pe (
        .CLK   (CLK),
        .RST_N (RST_N),
        .EN    (EN),
        .a_in  (w_a[r][c]),
        .b_in  (w_b[r][c]),
        .a_out (w_a[r][c+1]),
        .b_out (w_b[r+1][c]),
        .acc   (w_y[r*TILE_SIZE+c])
      );
    end
  end
endmodule

// File: tb/tb_systolic_tile.sv
// tb_systolic_tile: directed self-checking bench for the 8x8 systolic tile
module tb_systolic_tile;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic EN = 1'b0;
  logic [15:0] rx [8];
  logic [15:0] cx [8];
  wire [15:0] y [8][8];
  wire [15:0] ry [8];
  wire [15:0] cy [8];
  int n_chk = 0;
  int n_err = 0;
  always #5 CLK = ~CLK;
  systolic_tile dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN),
    .N_R0X(rx[0]), .N_R1X(rx[1]), .N_R2X(rx[2]), .N_R3X(rx[3]),
    .N_R4X(rx[4]), .N_R5X(rx[5]), .N_R6X(rx[6]), .N_R7X(rx[7]),
    .N_C0X(cx[0]), .N_C1X(cx[1]), .N_C2X(cx[2]), .N_C3X(cx[3]),
    .N_C4X(cx[4]), .N_C5X(cx[5]), .N_C6X(cx[6]), .N_C7X(cx[7]),
    .Y_00(y[0][0]), .Y_01(y[0][1]), .Y_02(y[0][2]), .Y_03(y[0][3]),
    .Y_04(y[0][4]), .Y_05(y[0][5]), .Y_06(y[0][6]), .Y_07(y[0][7]),
    .Y_10(y[1][0]), .Y_11(y[1][1]), .Y_12(y[1][2]), .Y_13(y[1][3]),
    .Y_14(y[1][4]), .Y_15(y[1][5]), .Y_16(y[1][6]), .Y_17(y[1][7]),
    .Y_20(y[2][0]), .Y_21(y[2][1]), .Y_22(y[2][2]), .Y_23(y[2][3]),
    .Y_24(y[2][4]), .Y_25(y[2][5]), .Y_26(y[2][6]), .Y_27(y[2][7]),
    .Y_30(y[3][0]), .Y_31(y[3][1]), .Y_32(y[3][2]), .Y_33(y[3][3]),
    .Y_34(y[3][4]), .Y_35(y[3][5]), .Y_36(y[3][6]), .Y_37(y[3][7]),
    .Y_40(y[4][0]), .Y_41(y[4][1]), .Y_42(y[4][2]), .Y_43(y[4][3]),
    .Y_44(y[4][4]), .Y_45(y[4][5]), .Y_46(y[4][6]), .Y_47(y[4][7]),
    .Y_50(y[5][0]), .Y_51(y[5][1]), .Y_52(y[5][2]), .Y_53(y[5][3]),
    .Y_54(y[5][4]), .Y_55(y[5][5]), .Y_56(y[5][6]), .Y_57(y[5][7]),
    .Y_60(y[6][0]), .Y_61(y[6][1]), .Y_62(y[6][2]), .Y_63(y[6][3]),
    .Y_64(y[6][4]), .Y_65(y[6][5]), .Y_66(y[6][6]), .Y_67(y[6][7]),
    .Y_70(y[7][0]), .Y_71(y[7][1]), .Y_72(y[7][2]), .Y_73(y[7][3]),
    .Y_74(y[7][4]), .Y_75(y[7][5]), .Y_76(y[7][6]), .Y_77(y[7][7]),
    .N_R0Y(ry[0]), .N_R1Y(ry[1]), .N_R2Y(ry[2]), .N_R3Y(ry[3]),
    .N_R4Y(ry[4]), .N_R5Y(ry[5]), .N_R6Y(ry[6]), .N_R7Y(ry[7]),
    .N_C0Y(cy[0]), .N_C1Y(cy[1]), .N_C2Y(cy[2]), .N_C3Y(cy[3]),
    .N_C4Y(cy[4]), .N_C5Y(cy[5]), .N_C6Y(cy[6]), .N_C7Y(cy[7])
  );
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d (0x%h) exp=%0d (0x%h)", tag, got, got, exp, exp);
    end
  endtask
  // value 1..8 presented on a lane starting at edge off, zero elsewhere
  function automatic logic [15:0] rmp(input int e, input int off);
    int k;
    k = e - off;
    return (k >= 0 && k < 8) ? 16'(k + 1) : 16'd0;
  endfunction
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic zero_in();
    for (int i = 0; i < 8; i++) begin
      rx[i] = '0;
      cx[i] = '0;
    end
  endtask
  task automatic do_reset();
    RST_N = 1'b0;
    #2;
    RST_N = 1'b1;
  endtask
  task automatic drive(input int e, input bit ident);
    for (int i = 0; i < 8; i++) begin
      rx[i] = ident ? ((e == 2 * i) ? 16'd1 : 16'd0) : rmp(e, i);
      cx[i] = rmp(e, i);
    end
  endtask
  task automatic chk_all(input string tag, input bit ident);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        chk($sformatf("%s_y%0d%0d", tag, r, c), y[r][c], ident ? 16'(r + 1) : 16'd204);
  endtask
  initial begin
    zero_in();
    #3;
    RST_N = 1'b1;
    EN = 1'b1;
    for (int e = 0; e < 5; e++) begin
      for (int i = 0; i < 8; i++) begin
        rx[i] = 16'($urandom);
        cx[i] = 16'($urandom);
      end
      tick();
    end
    RST_N = 1'b0;
    #1;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) chk($sformatf("rst_y%0d%0d", r, c), y[r][c], 16'd0);
      chk($sformatf("rst_ry%0d", r), ry[r], 16'd0);
      chk($sformatf("rst_cy%0d", r), cy[r], 16'd0);
    end
    #1;
    RST_N = 1'b1;
    for (int e = 0; e < 25; e++) begin
      drive(e, 1'b0);
      tick();
      if (e == 6) chk("ramp_y00_e6", y[0][0], 16'd140);
      if (e == 7) chk("ramp_y00_e7", y[0][0], 16'd204);
      if (e == 20) chk("ramp_y77_e20", y[7][7], 16'd140);
      if (e == 21) chk("ramp_y77_e21", y[7][7], 16'd204);
    end
    chk_all("ramp", 1'b0);
    zero_in();
    do_reset();
    for (int t = 0; t < 28; t++) begin
      EN = !(t >= 10 && t <= 12);
      drive(t < 10 ? t : (t <= 12 ? 10 : t - 3), 1'b0);
      tick();
      if (t == 12) chk("hold_y77_t12", y[7][7], 16'd0);
      if (t == 23) chk("hold_y77_t23", y[7][7], 16'd140);
      if (t == 24) chk("hold_y77_t24", y[7][7], 16'd204);
    end
    EN = 1'b1;
    chk_all("hold", 1'b0);
    zero_in();
    do_reset();
    rx[0] = 16'd300;
    cx[0] = 16'd300;
    tick();
    chk("wrap_300sq", y[0][0], 16'd24464);
    rx[0] = 16'hFFFF;
    cx[0] = 16'hFFFF;
    tick();
    chk("wrap_ffff_sq", y[0][0], 16'd24465);
    zero_in();
    do_reset();
    rx[3] = 16'hA5A5;
    cx[5] = 16'h1234;
    tick();
    zero_in();
    for (int n = 2; n <= 9; n++) begin
      tick();
      if (n == 7) begin
        chk("pipe_r3_n7", ry[3], 16'd0);
        chk("pipe_c5_n7", cy[5], 16'd0);
      end
      if (n == 8) begin
        chk("pipe_r3_n8", ry[3], 16'hA5A5);
        chk("pipe_c5_n8", cy[5], 16'h1234);
        chk("pipe_r2_n8", ry[2], 16'd0);
      end
      if (n == 9) begin
        chk("pipe_r3_n9", ry[3], 16'd0);
        chk("pipe_c5_n9", cy[5], 16'd0);
      end
    end
    do_reset();
    for (int e = 0; e < 25; e++) begin
      drive(e, 1'b1);
      tick();
    end
    chk_all("ident", 1'b1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
